buffer_reader: RTL

Read-side drain for the SPI sample circular buffer. It tracks buffer occupancy from the writer's write strobe and issues reads to the block-RAM read port. Each word it fetches is presented on a valid/ready stream to the downstream consumer (host/output path). It detects and reports writer lap-around (overrun) and drops the oldest word in that case.

---
 rtl/buffer_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/buffer_reader.sv
// rtl/buffer_reader.sv - read-side drain of the sample circular buffer
// Tracks occupancy from write strobes, fetches words from block RAM, streams them out.
module buffer_reader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_pulse,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clear
);

  localparam logic [ADDR_W:0]   FULL    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_LVL = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_PTR = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic              LAT_LAST = (RD_LAT == 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   word_q;
  logic                valid_q;
  logic                lat_cnt_q;
  logic                overrun;

  // An overrun in the same cycle as the next issue decision must already
  // skip the dropped word, so the issue address is taken from rd_ptr_d.
  always_comb begin
    level_d  = level_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    overrun  = 1'b0;
    if (rd_en_q) rd_ptr_d = rd_ptr_q + ONE_PTR;
    if (write_pulse && !rd_en_q) begin
      if (level_q == FULL) begin
        overrun  = 1'b1;
        rd_ptr_d = rd_ptr_q + ONE_PTR;
      end else begin
        level_d = level_q + ONE_LVL;
      end
    end else if (rd_en_q && !write_pulse) begin
      level_d = level_q - ONE_LVL;
    end
    if (ovf_clear) ovf_d = 1'b0;
    if (overrun) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      lat_cnt_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      rd_en_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (level_q != '0 && !valid_q) begin
            state_q   <= S_ISSUE;
            rd_en_q   <= 1'b1;
            rd_addr_q <= rd_ptr_d;
          end
        end
        S_ISSUE: begin
          state_q   <= S_WAIT;
          lat_cnt_q <= 1'b0;
        end
        S_WAIT: begin
          if (lat_cnt_q == LAT_LAST) begin
            word_q  <= rd_data;
            valid_q <= 1'b1;
            state_q <= S_PRESENT;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        S_PRESENT: begin
          if (word_ready) begin
            valid_q <= 1'b0;
            if (level_q != '0) begin
              state_q   <= S_ISSUE;
              rd_en_q   <= 1'b1;
              rd_addr_q <= rd_ptr_d;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign level      = level_q;
  assign empty      = (level_q == '0);
  assign overflow   = ovf_q;

endmodule
